cdb_req_buffer: RTL and testbench

per-FU completion buffer on the requester side of the CDB request/grant protocol. It holds finished results, requests a CDB slot, and presents the head entry when the grant returns.

Interface
REQ-001 Parameter DEPTH, default 4, result FIFO entries (power of 2, >=2).
REQ-002 Parameter TAG_W, default 6, physical-register tag width.
REQ-003 Parameter DATA_W, default 32, result data width.
REQ-004 clock  input  1  clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  FU presents a completed result this cycle.
REQ-007 in_tag  input  TAG_W  destination physical tag of the incoming result.
REQ-008 in_data  input  DATA_W  incoming result value.
REQ-009 in_ready  output  1  buffer can accept in_valid this cycle.
REQ-010 flush  input  1  squash: discard all held and incoming results.
REQ-011 cdb_req  output  1  request for a CDB slot; the arbiter answers one cycle later.
REQ-012 cdb_gnt  input  1  grant for the cdb_req of the previous cycle.
REQ-013 out_valid  output  1  valid bit of the entry driven to the CDB this cycle.
REQ-014 out_tag  output  TAG_W  tag of the driven entry.
REQ-015 out_data  output  DATA_W  data of the driven entry.
REQ-016 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 Storage is a circular FIFO with head pointer, tail pointer and count; pointers wrap modulo DEPTH.
REQ-018 in_ready SHALL equal (count < DEPTH) || cdb_gnt, so a pop in the same cycle frees a slot for a push.
REQ-019 A push occurs when in_valid && in_ready && !flush: the entry is written at tail, tail advances and count increments at the next edge.
REQ-020 A pop occurs when cdb_gnt && count>0 && !flush: head advances and count decrements at the next edge.
REQ-021 out_valid/out_tag/out_data SHALL be combinational: head entry with out_valid=1 when cdb_gnt && count>0; otherwise all zero.
REQ-022 cdb_req SHALL be combinational and equal (count - (cdb_gnt && count>0)) > 0 && !flush, i.e. it requests the next entry behind any entry being popped.
REQ-023 A same-cycle push is not requested until the following cycle; there is no bypass to out_* or cdb_req.
REQ-024 A denied request (cdb_gnt=0 the cycle after cdb_req=1) leaves the FIFO unchanged, and the request is re-raised while entries remain.
REQ-025 Simultaneous push and pop: count unchanged, both pointers advance, and the entry order is preserved.
REQ-026 Push into a full buffer with no grant is blocked by in_ready=0; the stored state SHALL NOT change.
REQ-027 cdb_gnt with count==0 (for example a grant after a flush): out_valid=0, state unchanged, no error.
REQ-028 flush: out_valid=0 and cdb_req=0 that cycle; next edge sets count=0 and head=tail=0; incoming in_valid is dropped.
REQ-029 Results leave in strict FIFO order; latency from push to earliest out_valid is 2 cycles (req at t+1, grant at t+2).

Reset
REQ-030 While reset is high at a posedge, count, head and tail SHALL clear to 0, and the stored entries need not clear.
REQ-031 After reset: cdb_req=0, out_valid=0, out_tag=0, out_data=0, in_ready=1.
REQ-032 Reset mid-operation discards all entries, and a grant arriving the cycle after reset yields out_valid=0.
REQ-033 Reset has priority over flush, push and pop.

Verification
REQ-034 Single push tag=5 data=0xAA at cycle 0, cdb_gnt=1 at cycle 2 -> cdb_req=1 at cycle 1; out_valid=1, tag=5, data=0xAA at cycle 2; count=0 after.
REQ-035 Push 4 entries (tags 1-4) with no grant -> count=4, in_ready=0, fifth push is ignored; then 4 consecutive grants -> tags out in order 1,2,3,4, and cdb_req drops in the cycle the 4th is granted.
REQ-036 Grant withheld for 3 cycles with 1 entry -> cdb_req held at 1, count=1 throughout; grant on cycle 4 -> entry out, count=0.
REQ-037 Full buffer, push tag=9 with cdb_gnt=1 in the same cycle -> head pops, tag 9 is accepted, count stays 4, and the order is preserved.
REQ-038 3 entries held, flush with cdb_gnt=1 -> out_valid=0, co

---
 rtl/cdb_req_buffer.sv | 64 ++++++
 tb/tb_cdb_req_buffer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cdb_req_buffer.sv
// rtl/cdb_req_buffer.sv - per-FU completion FIFO that requests a CDB slot and drives the head on grant
// Grant answers the previous cycle's request; a granted entry is popped in the same cycle it is driven.
module cdb_req_buffer #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       cdb_req,
  input  logic                       cdb_gnt,
  output logic                       out_valid,
  output logic [TAG_W-1:0]           out_tag,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count_q;
  logic              push, pop;

  assign count = count_q;

  always_comb begin
    pop      = cdb_gnt && (count_q != '0) && !flush;
    in_ready = (count_q < FULL) || cdb_gnt;
    push     = in_valid && in_ready && !flush;
    // Request only for entries left behind the one leaving now; a same-cycle push waits a cycle.
    cdb_req  = !flush && (count_q > (pop ? CW'(1) : CW'(0)));
    out_valid = pop;
    out_tag   = pop ? tag_mem[head]  : '0;
    out_data  = pop ? data_mem[head] : '0;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !reset) begin
      tag_mem[tail]  <= in_tag;
      data_mem[tail] <= in_data;
    end
  end
endmodule

// File: tb/tb_cdb_req_buffer.sv
// tb/tb_cdb_req_buffer.sv - directed table, corner sequences and queue-model random test for cdb_req_buffer
module tb_cdb_req_buffer;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset, in_valid, flush, cdb_gnt;
  logic [TAG_W-1:0]  in_tag;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, cdb_req, out_valid;
  logic [TAG_W-1:0]  out_tag;
  logic [DATA_W-1:0] out_data;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  cdb_req_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_tag(in_tag), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .cdb_req(cdb_req), .cdb_gnt(cdb_gnt),
    .out_valid(out_valid), .out_tag(out_tag), .out_data(out_data), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, iv;
    logic [5:0]  tag;
    logic [31:0] data;
    logic        fl, gnt;
    logic        e_req, e_ov;
    logic [5:0]  e_tag;
    logic [31:0] e_data;
    logic [2:0]  e_cnt;
    logic        e_rdy;
  } vec_t;

  vec_t vecs [19];

  task automatic drive(input logic r, input logic iv, input logic [TAG_W-1:0] t,
                       input logic [DATA_W-1:0] d, input logic f, input logic g);
    @(negedge clock);
    reset = r; in_valid = iv; in_tag = t; in_data = d; flush = f; cdb_gnt = g;
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag_name, input logic e_req, input logic e_ov,
                         input logic [TAG_W-1:0] e_tag, input logic [DATA_W-1:0] e_data,
                         input int e_cnt, input logic e_rdy);
    chk({tag_name, ".cdb_req"},   cdb_req,   e_req);
    chk({tag_name, ".out_valid"}, out_valid, e_ov);
    chk({tag_name, ".out_tag"},   out_tag,   e_tag);
    chk({tag_name, ".out_data"},  out_data,  e_data);
    chk({tag_name, ".count"},     count,     e_cnt);
    chk({tag_name, ".in_ready"},  in_ready,  e_rdy);
  endtask

  logic [TAG_W+DATA_W-1:0] q [$];
  logic [TAG_W+DATA_W-1:0] head_e;
  logic r, iv, f, g, e_ov, e_req, e_rdy, prev_req;
  logic [TAG_W-1:0]  t;
  logic [DATA_W-1:0] d;
  int cnt;

  initial begin
    //              rst iv tag data  fl gnt  req ov etag edata  cnt rdy
    vecs[0]  = '{0, 0, 0, 0,     0, 0,  0, 0, 0, 0,     0, 1};
    vecs[1]  = '{0, 1, 5, 'hAA,  0, 0,  0, 0, 0, 0,     0, 1};
    vecs[2]  = '{0, 0, 0, 0,     0, 0,  1, 0, 0, 0,     1, 1};
    vecs[3]  = '{0, 0, 0, 0,     0, 1,  0, 1, 5, 'hAA,  1, 1};
    vecs[4]  = '{0, 0, 0, 0,     0, 0,  0, 0, 0, 0,     0, 1};
    vecs[5]  = '{0, 1, 1, 'h11,  0, 0,  0, 0, 0, 0,     0, 1};
    vecs[6]  = '{0, 1, 2, 'h22,  0, 0,  1, 0, 0, 0,     1, 1};
    vecs[7]  = '{0, 1, 3, 'h33,  0, 0,  1, 0, 0, 0,     2, 1};
    vecs[8]  = '{0, 1, 4, 'h44,  0, 0,  1, 0, 0, 0,     3, 1};
    vecs[9]  = '{0, 1, 6, 'h66,  0, 0,  1, 0, 0, 0,     4, 0};
    vecs[10] = '{0, 1, 9, 'h99,  0, 1,  1, 1, 1, 'h11,  4, 1};
    vecs[11] = '{0, 0, 0, 0,     0, 1,  1, 1, 2, 'h22,  4, 1};
    vecs[12] = '{0, 0, 0, 0,     1, 1,  0, 0, 0, 0,     3, 1};
    vecs[13] = '{0, 0, 0, 0,     0, 1,  0, 0, 0, 0,     0, 1};
    vecs[14] = '{0, 1, 7, 'h77,  0, 0,  0, 0, 0, 0,     0, 1};
    vecs[15] = '{0, 1, 8, 'h88,  0, 0,  1, 0, 0, 0,     1, 1};
    vecs[16] = '{1, 0, 0, 0,     0, 0,  1, 0, 0, 0,     2, 1};
    vecs[17] = '{0, 0, 0, 0,     0, 1,  0, 0, 0, 0,     0, 1};
    vecs[18] = '{0, 0, 0, 0,     0, 0,  0, 0, 0, 0,     0, 1};

    reset = 1'b1; in_valid = 1'b0; in_tag = '0; in_data = '0; flush = 1'b0; cdb_gnt = 1'b0;
    drive(1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].tag, vecs[i].data, vecs[i].fl, vecs[i].gnt);
      chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_ov, vecs[i].e_tag,
              vecs[i].e_data, int'(vecs[i].e_cnt), vecs[i].e_rdy);
    end

    // Fill, blocked fifth push, push-with-pop on full, then drain in order.
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) drive(0, 1, TAG_W'(i), DATA_W'(i * 'h100), 0, 0);
    drive(0, 1, 6, 'h600, 0, 0);
    chk_all("full_block", 1, 0, 0, 0, 4, 0);
    drive(0, 1, 9, 'h900, 0, 1);
    chk_all("full_pushpop", 1, 1, 1, 'h100, 4, 1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1);
      chk_all($sformatf("drain%0d", i), (i < 3), 1, (i < 3) ? TAG_W'(i + 2) : TAG_W'(9),
              (i < 3) ? DATA_W'((i + 2) * 'h100) : DATA_W'('h900), 4 - i, 1);
    end
    drive(0, 0, 0, 0, 0, 0);
    chk_all("drained", 0, 0, 0, 0, 0, 1);

    // Denied grants keep the request up and the entry in place.
    drive(0, 1, 3, 'h5A5A, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk_all($sformatf("deny%0d", i), 1, 0, 0, 0, 1, 1);
    end
    drive(0, 0, 0, 0, 0, 1);
    chk_all("late_gnt", 0, 1, 3, 'h5A5A, 1, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk_all("late_gnt_after", 0, 0, 0, 0, 0, 1);

    // Randomized run against a queue model.
    drive(1, 0, 0, 0, 0, 0);
    q.delete();
    prev_req = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom % 128) == 0;
      iv = ($urandom % 8) < 5;
      f  = ($urandom % 40) == 0;
      g  = (prev_req && ($urandom % 4) != 0) || (($urandom % 16) == 0);
      t  = TAG_W'($urandom);
      d  = $urandom;
      drive(r, iv, t, d, f, g);
      cnt   = q.size();
      e_ov  = g && cnt > 0 && !f;
      e_req = !f && (cnt - (e_ov ? 1 : 0)) > 0;
      e_rdy = cnt < DEPTH || g;
      head_e = (cnt > 0) ? q[0] : '0;
      chk_all($sformatf("rnd%0d", n), e_req, e_ov,
              e_ov ? head_e[TAG_W+DATA_W-1:DATA_W] : '0,
              e_ov ? head_e[DATA_W-1:0] : '0, cnt, e_rdy);
      prev_req = e_req;
      if (r || f) q.delete();
      else begin
        if (e_ov) void'(q.pop_front());
        if (iv && e_rdy) q.push_back({t, d});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
